// File: rtl/neuron_accumulator.sv
// ---------------------------------------------------------------------------
// neuron_accumulator
//   Serial multiply-accumulate neuron for the XOR network. It consumes
//   N_INPUTS (x, w) pairs over a valid/ready stream. The bias is added with
//   the first pair. The signed sum is clamped to [-16, +16] and emitted as a
//   sign + thermometer code for the sigmoid activation stage.
//
//   Optional feature macro: NEURON_FRAC_SHIFT_EN
//     When defined, the product sum is treated as fixed point with FRAC_BITS
//     fractional bits. The bias is pre-shifted into that format. The final sum
//     is rounded half up and shifted back to an integer before clamping.
//     When undefined, all arithmetic is integer and FRAC_BITS has no effect.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous reset, active high
//   in_valid   in   1       in_x/in_w pair valid
//   in_ready   out  1       block accepts a pair this cycle (ACC state)
//   in_x       in   DATA_W  signed activation input
//   in_w       in   DATA_W  signed weight
//   bias       in   DATA_W  signed bias, sampled with the first pair
//   out_valid  out  1       out_code valid (OUT state)
//   out_ready  in   1       downstream accepts out_code
//   out_code   out  17      bit16 = sign, bits[15:0] = thermometer magnitude
//   out_sat    out  1       magnitude exceeded 16 and was clamped
// ---------------------------------------------------------------------------
module neuron_accumulator #(
    parameter int N_INPUTS  = 2,
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 20,
    parameter int FRAC_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_x,
    input  logic signed [DATA_W-1:0] in_w,
    input  logic signed [DATA_W-1:0] bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [16:0]              out_code,
    output logic                     out_sat
);

    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_INPUTS - 1);
    localparam logic [ACC_W-1:0] SAT_LIMIT = ACC_W'(16);

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_FINAL = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    // k ones, LSB-aligned; k is already clamped to 0..16.
    function automatic logic [15:0] therm_encode(input logic [4:0] k);
        logic [15:0] code;
        code = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (5'(i) < k) begin
                code[i] = 1'b1;
            end else begin
                code[i] = 1'b0;
            end
        end
        return code;
    endfunction

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [16:0]             out_code_q, out_code_d;
    logic                    out_sat_q, out_sat_d;

    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    prod_ext_s;
    logic signed [ACC_W-1:0]    bias_ext_s;
    logic signed [ACC_W-1:0]    sum_s;
    logic                       sum_neg_s;
    logic [ACC_W-1:0]           mag_s;
    logic                       sat_s;
    logic [4:0]                 k_s;

    // Product, bias alignment and the clamped magnitude of the final sum.
    always_comb begin
        prod_s     = in_x * in_w;
        prod_ext_s = ACC_W'(prod_s);
`ifdef NEURON_FRAC_SHIFT_EN
        bias_ext_s = ACC_W'(bias) <<< FRAC_BITS;
        // Add half an LSB before the arithmetic shift: round half up.
        sum_s      = (acc_q + (ACC_W'(1) <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
`else
        bias_ext_s = ACC_W'(bias);
        sum_s      = acc_q;
`endif
        sum_neg_s  = sum_s[ACC_W-1];
        if (sum_neg_s) begin
            mag_s = ACC_W'(-sum_s);
        end else begin
            mag_s = ACC_W'(sum_s);
        end
        sat_s = (mag_s > SAT_LIMIT);
        if (sat_s) begin
            k_s = 5'd16;
        end else begin
            k_s = mag_s[4:0];
        end
    end

    // Next-state logic for the ACC -> FINAL -> OUT evaluation cycle.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        out_code_d = out_code_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            ST_ACC: begin
                if (in_valid) begin
                    if (idx_q == {IDX_W{1'b0}}) begin
                        acc_d = bias_ext_s + prod_ext_s;
                    end else begin
                        acc_d = acc_q + prod_ext_s;
                    end
                    if (idx_q == IDX_LAST) begin
                        idx_d   = {IDX_W{1'b0}};
                        state_d = ST_FINAL;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_FINAL: begin
                out_code_d = {sum_neg_s, therm_encode(k_s)};
                out_sat_d  = sat_s;
                state_d    = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    idx_d   = {IDX_W{1'b0}};
                    state_d = ST_ACC;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                idx_d   = {IDX_W{1'b0}};
                state_d = ST_ACC;
            end
        endcase
    end

    // State, accumulator and result registers; reset discards any partial sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ACC;
            idx_q      <= {IDX_W{1'b0}};
            acc_q      <= {ACC_W{1'b0}};
            out_code_q <= 17'h00000;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            out_code_q <= out_code_d;
            out_sat_q  <= out_sat_d;
        end
    end

    // Handshake outputs decode the registered state only, so neither ready
    // nor valid depends combinationally on the opposite side.
    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_OUT);
    assign out_code  = out_code_q;
    assign out_sat   = out_sat_q;

endmodule
